// File: rtl/prediction_reader.sv
// Prediction table reader: SP/LHP/GHP stat+trend tables, confidence-based predictor selection, IF/ID/EX copies.
// Optional build macro TREND_BIAS_EN adds the signed trend counter into each selection score.
module prediction_reader #(
  parameter int JUMP_STATUS_COUNTER_WIDTH = 2,
  parameter int STAT_COUNTER_WIDTH        = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 PL_stall,
  input  logic                                 PL_flush,
  input  logic [2:0]                           addr,
  input  logic                                 SP_prediction_result,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count,
  input  logic                                 clear_en1,
  input  logic [2:0]                           WR_addr1,
  input  logic                                 WR_SP_index1,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_LHP_index1,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_GHP_index1,
  input  logic                                 WR_SP_stat_en1,
  input  logic                                 WR_SP_trend_en1,
  input  logic [STAT_COUNTER_WIDTH-1:0]        WR_SP_stat_count1,
  input  logic [2:0]                           WR_SP_trend_count1,
  input  logic                                 WR_LHP_stat_en1,
  input  logic                                 WR_LHP_trend_en1,
  input  logic [STAT_COUNTER_WIDTH-1:0]        WR_LHP_stat_count1,
  input  logic [2:0]                           WR_LHP_trend_count1,
  input  logic                                 WR_GHP_stat_en1,
  input  logic                                 WR_GHP_trend_en1,
  input  logic [STAT_COUNTER_WIDTH-1:0]        WR_GHP_stat_count1,
  input  logic [2:0]                           WR_GHP_trend_count1,
  input  logic                                 clear_en2,
  input  logic [2:0]                           WR_addr2,
  input  logic                                 WR_SP_index2,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_LHP_index2,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_GHP_index2,
  input  logic                                 WR_SP_stat_en2,
  input  logic                                 WR_SP_trend_en2,
  input  logic [STAT_COUNTER_WIDTH-1:0]        WR_SP_stat_count2,
  input  logic [2:0]                           WR_SP_trend_count2,
  input  logic                                 WR_LHP_stat_en2,
  input  logic                                 WR_LHP_trend_en2,
  input  logic [STAT_COUNTER_WIDTH-1:0]        WR_LHP_stat_count2,
  input  logic [2:0]                           WR_LHP_trend_count2,
  input  logic                                 WR_GHP_stat_en2,
  input  logic                                 WR_GHP_trend_en2,
  input  logic [STAT_COUNTER_WIDTH-1:0]        WR_GHP_stat_count2,
  input  logic [2:0]                           WR_GHP_trend_count2,
  output logic                                 prediction_result,
  output logic                                 prediction_result_id,
  output logic                                 prediction_result_ex,
  output logic [2:0]                           addr_id,
  output logic [2:0]                           addr_ex,
  output logic                                 SP_prediction_result_id,
  output logic                                 SP_prediction_result_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count_id,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count_ex,
  output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count_id,
  output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count_ex,
  output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count_id,
  output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count_ex,
  output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count_id,
  output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count_ex,
  output logic [2:0]                           SP_trend_count,
  output logic [2:0]                           LHP_trend_count,
  output logic [2:0]                           GHP_trend_count
);
  localparam int JW  = JUMP_STATUS_COUNTER_WIDTH;
  localparam int SW  = STAT_COUNTER_WIDTH;
  localparam int JD  = 8 << JW;
  localparam int SCW = SW + 2;

  typedef enum logic [1:0] {SEL_SP, SEL_LHP, SEL_GHP} sel_e;

  typedef struct packed {
    logic          pred;
    logic [2:0]    addr;
    logic          sp_res;
    logic [JW-1:0] lhp_cnt;
    logic [JW-1:0] ghp_cnt;
    logic [SW-1:0] sp_stat;
    logic [SW-1:0] lhp_stat;
    logic [SW-1:0] ghp_stat;
  } pipe_t;

  logic [SW-1:0] r_sp_stat  [16];
  logic [2:0]    r_sp_trend [16];
  logic [SW-1:0] r_lhp_stat [JD];
  logic [2:0]    r_lhp_trend[JD];
  logic [SW-1:0] r_ghp_stat [JD];
  logic [2:0]    r_ghp_trend[JD];

  // NOTE: the tables must come out of reset zeroed, so these arrays are reset flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_sp_stat[i]  <= '0;
        r_sp_trend[i] <= '0;
      end
      for (int i = 0; i < JD; i++) begin
        r_lhp_stat[i]  <= '0;
        r_lhp_trend[i] <= '0;
        r_ghp_stat[i]  <= '0;
        r_ghp_trend[i] <= '0;
      end
    end else begin
      // Later assignments win: port 1, then port 2, then row clears.
      if (WR_SP_stat_en1)   r_sp_stat  [{WR_addr1, WR_SP_index1}]  <= WR_SP_stat_count1;
      if (WR_SP_trend_en1)  r_sp_trend [{WR_addr1, WR_SP_index1}]  <= WR_SP_trend_count1;
      if (WR_LHP_stat_en1)  r_lhp_stat [{WR_addr1, WR_LHP_index1}] <= WR_LHP_stat_count1;
      if (WR_LHP_trend_en1) r_lhp_trend[{WR_addr1, WR_LHP_index1}] <= WR_LHP_trend_count1;
      if (WR_GHP_stat_en1)  r_ghp_stat [{WR_addr1, WR_GHP_index1}] <= WR_GHP_stat_count1;
      if (WR_GHP_trend_en1) r_ghp_trend[{WR_addr1, WR_GHP_index1}] <= WR_GHP_trend_count1;
      if (WR_SP_stat_en2)   r_sp_stat  [{WR_addr2, WR_SP_index2}]  <= WR_SP_stat_count2;
      if (WR_SP_trend_en2)  r_sp_trend [{WR_addr2, WR_SP_index2}]  <= WR_SP_trend_count2;
      if (WR_LHP_stat_en2)  r_lhp_stat [{WR_addr2, WR_LHP_index2}] <= WR_LHP_stat_count2;
      if (WR_LHP_trend_en2) r_lhp_trend[{WR_addr2, WR_LHP_index2}] <= WR_LHP_trend_count2;
      if (WR_GHP_stat_en2)  r_ghp_stat [{WR_addr2, WR_GHP_index2}] <= WR_GHP_stat_count2;
      if (WR_GHP_trend_en2) r_ghp_trend[{WR_addr2, WR_GHP_index2}] <= WR_GHP_trend_count2;
      if (clear_en1) begin
        for (int i = 0; i < 2; i++) r_sp_stat[{WR_addr1, 1'(i)}] <= '0;
        for (int i = 0; i < (1 << JW); i++) begin
          r_lhp_stat[{WR_addr1, JW'(i)}] <= '0;
          r_ghp_stat[{WR_addr1, JW'(i)}] <= '0;
        end
      end
      if (clear_en2) begin
        for (int i = 0; i < 2; i++) r_sp_stat[{WR_addr2, 1'(i)}] <= '0;
        for (int i = 0; i < (1 << JW); i++) begin
          r_lhp_stat[{WR_addr2, JW'(i)}] <= '0;
          r_ghp_stat[{WR_addr2, JW'(i)}] <= '0;
        end
      end
    end
  end

  assign SP_stat_count   = r_sp_stat  [{addr, SP_prediction_result}];
  assign SP_trend_count  = r_sp_trend [{addr, SP_prediction_result}];
  assign LHP_stat_count  = r_lhp_stat [{addr, LHP_count}];
  assign LHP_trend_count = r_lhp_trend[{addr, LHP_count}];
  assign GHP_stat_count  = r_ghp_stat [{addr, GHP_count}];
  assign GHP_trend_count = r_ghp_trend[{addr, GHP_count}];

  logic signed [SCW-1:0] w_sp_bias, w_lhp_bias, w_ghp_bias;
  logic signed [SCW-1:0] w_sp_score, w_lhp_score, w_ghp_score;

`ifdef TREND_BIAS_EN
  assign w_sp_bias  = SCW'($signed(SP_trend_count));
  assign w_lhp_bias = SCW'($signed(LHP_trend_count));
  assign w_ghp_bias = SCW'($signed(GHP_trend_count));
`else
  assign w_sp_bias  = '0;
  assign w_lhp_bias = '0;
  assign w_ghp_bias = '0;
`endif

  // Two zero guard bits keep the stat count non-negative in the signed domain.
  assign w_sp_score  = $signed({2'b00, SP_stat_count})  + w_sp_bias;
  assign w_lhp_score = $signed({2'b00, LHP_stat_count}) + w_lhp_bias;
  assign w_ghp_score = $signed({2'b00, GHP_stat_count}) + w_ghp_bias;

  sel_e w_sel;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel = SEL_SP;
    if (w_ghp_score >= w_lhp_score && w_ghp_score >= w_sp_score) w_sel = SEL_GHP;
    else if (w_lhp_score >= w_sp_score)                          w_sel = SEL_LHP;
  end

  always_comb begin
    prediction_result = SP_prediction_result;
    case (w_sel)
      SEL_LHP: prediction_result = LHP_count[JW-1];
      SEL_GHP: prediction_result = GHP_count[JW-1];
      default: prediction_result = SP_prediction_result;
    endcase
  end

  pipe_t w_if, r_id, r_ex;

  assign w_if = '{pred: prediction_result, addr: addr, sp_res: SP_prediction_result,
                  lhp_cnt: LHP_count, ghp_cnt: GHP_count, sp_stat: SP_stat_count,
                  lhp_stat: LHP_stat_count, ghp_stat: GHP_stat_count};

  // NOTE: sequential state uses non-blocking assignments so EX samples the pre-edge ID copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id <= '0;
      r_ex <= '0;
    end else if (!PL_stall) begin
      r_id <= PL_flush ? '0 : w_if;
      r_ex <= r_id;
    end
  end

  assign prediction_result_id    = r_id.pred;
  assign prediction_result_ex    = r_ex.pred;
  assign addr_id                 = r_id.addr;
  assign addr_ex                 = r_ex.addr;
  assign SP_prediction_result_id = r_id.sp_res;
  assign SP_prediction_result_ex = r_ex.sp_res;
  assign LHP_count_id            = r_id.lhp_cnt;
  assign LHP_count_ex            = r_ex.lhp_cnt;
  assign GHP_count_id            = r_id.ghp_cnt;
  assign GHP_count_ex            = r_ex.ghp_cnt;
  assign SP_stat_count_id        = r_id.sp_stat;
  assign SP_stat_count_ex        = r_ex.sp_stat;
  assign LHP_stat_count_id       = r_id.lhp_stat;
  assign LHP_stat_count_ex       = r_ex.lhp_stat;
  assign GHP_stat_count_id       = r_id.ghp_stat;
  assign GHP_stat_count_ex       = r_ex.ghp_stat;

endmodule

// File: tb/tb_prediction_reader.sv
// Directed bench for prediction_reader: reset, writes, dual-port priority, clears, ties, pipeline, trend, async reset.
module tb_prediction_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PL_stall = 1'b0, PL_flush = 1'b0;
  logic [2:0] addr = '0;
  logic SP_prediction_result = 1'b0;
  logic [1:0] LHP_count = '0, GHP_count = '0;
  logic clear_en1, WR_SP_index1, WR_SP_stat_en1, WR_SP_trend_en1, WR_LHP_stat_en1, WR_LHP_trend_en1, WR_GHP_stat_en1, WR_GHP_trend_en1;
  logic clear_en2, WR_SP_index2, WR_SP_stat_en2, WR_SP_trend_en2, WR_LHP_stat_en2, WR_LHP_trend_en2, WR_GHP_stat_en2, WR_GHP_trend_en2;
  logic [2:0] WR_addr1, WR_addr2, WR_SP_trend_count1, WR_LHP_trend_count1, WR_GHP_trend_count1;
  logic [2:0] WR_SP_trend_count2, WR_LHP_trend_count2, WR_GHP_trend_count2;
  logic [1:0] WR_LHP_index1, WR_GHP_index1, WR_LHP_index2, WR_GHP_index2;
  logic [4:0] WR_SP_stat_count1, WR_LHP_stat_count1, WR_GHP_stat_count1;
  logic [4:0] WR_SP_stat_count2, WR_LHP_stat_count2, WR_GHP_stat_count2;

  logic prediction_result, prediction_result_id, prediction_result_ex;
  logic [2:0] addr_id, addr_ex;
  logic SP_prediction_result_id, SP_prediction_result_ex;
  logic [1:0] LHP_count_id, LHP_count_ex, GHP_count_id, GHP_count_ex;
  logic [4:0] SP_stat_count, SP_stat_count_id, SP_stat_count_ex;
  logic [4:0] LHP_stat_count, LHP_stat_count_id, LHP_stat_count_ex;
  logic [4:0] GHP_stat_count, GHP_stat_count_id, GHP_stat_count_ex;
  logic [2:0] SP_trend_count, LHP_trend_count, GHP_trend_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prediction_reader #(.JUMP_STATUS_COUNTER_WIDTH(2), .STAT_COUNTER_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .PL_flush(PL_flush), .addr(addr),
    .SP_prediction_result(SP_prediction_result), .LHP_count(LHP_count), .GHP_count(GHP_count),
    .clear_en1(clear_en1), .WR_addr1(WR_addr1), .WR_SP_index1(WR_SP_index1),
    .WR_LHP_index1(WR_LHP_index1), .WR_GHP_index1(WR_GHP_index1),
    .WR_SP_stat_en1(WR_SP_stat_en1), .WR_SP_trend_en1(WR_SP_trend_en1),
    .WR_SP_stat_count1(WR_SP_stat_count1), .WR_SP_trend_count1(WR_SP_trend_count1),
    .WR_LHP_stat_en1(WR_LHP_stat_en1), .WR_LHP_trend_en1(WR_LHP_trend_en1),
    .WR_LHP_stat_count1(WR_LHP_stat_count1), .WR_LHP_trend_count1(WR_LHP_trend_count1),
    .WR_GHP_stat_en1(WR_GHP_stat_en1), .WR_GHP_trend_en1(WR_GHP_trend_en1),
    .WR_GHP_stat_count1(WR_GHP_stat_count1), .WR_GHP_trend_count1(WR_GHP_trend_count1),
    .clear_en2(clear_en2), .WR_addr2(WR_addr2), .WR_SP_index2(WR_SP_index2),
    .WR_LHP_index2(WR_LHP_index2), .WR_GHP_index2(WR_GHP_index2),
    .WR_SP_stat_en2(WR_SP_stat_en2), .WR_SP_trend_en2(WR_SP_trend_en2),
    .WR_SP_stat_count2(WR_SP_stat_count2), .WR_SP_trend_count2(WR_SP_trend_count2),
    .WR_LHP_stat_en2(WR_LHP_stat_en2), .WR_LHP_trend_en2(WR_LHP_trend_en2),
    .WR_LHP_stat_count2(WR_LHP_stat_count2), .WR_LHP_trend_count2(WR_LHP_trend_count2),
    .WR_GHP_stat_en2(WR_GHP_stat_en2), .WR_GHP_trend_en2(WR_GHP_trend_en2),
    .WR_GHP_stat_count2(WR_GHP_stat_count2), .WR_GHP_trend_count2(WR_GHP_trend_count2),
    .prediction_result(prediction_result), .prediction_result_id(prediction_result_id),
    .prediction_result_ex(prediction_result_ex), .addr_id(addr_id), .addr_ex(addr_ex),
    .SP_prediction_result_id(SP_prediction_result_id), .SP_prediction_result_ex(SP_prediction_result_ex),
    .LHP_count_id(LHP_count_id), .LHP_count_ex(LHP_count_ex),
    .GHP_count_id(GHP_count_id), .GHP_count_ex(GHP_count_ex),
    .SP_stat_count(SP_stat_count), .SP_stat_count_id(SP_stat_count_id), .SP_stat_count_ex(SP_stat_count_ex),
    .LHP_stat_count(LHP_stat_count), .LHP_stat_count_id(LHP_stat_count_id), .LHP_stat_count_ex(LHP_stat_count_ex),
    .GHP_stat_count(GHP_stat_count), .GHP_stat_count_id(GHP_stat_count_id), .GHP_stat_count_ex(GHP_stat_count_ex),
    .SP_trend_count(SP_trend_count), .LHP_trend_count(LHP_trend_count), .GHP_trend_count(GHP_trend_count)
  );

  task automatic idle_writes();
    {clear_en1, WR_SP_index1, WR_SP_stat_en1, WR_SP_trend_en1, WR_LHP_stat_en1, WR_LHP_trend_en1, WR_GHP_stat_en1, WR_GHP_trend_en1} = '0;
    {clear_en2, WR_SP_index2, WR_SP_stat_en2, WR_SP_trend_en2, WR_LHP_stat_en2, WR_LHP_trend_en2, WR_GHP_stat_en2, WR_GHP_trend_en2} = '0;
    {WR_addr1, WR_addr2, WR_SP_trend_count1, WR_LHP_trend_count1, WR_GHP_trend_count1} = '0;
    {WR_SP_trend_count2, WR_LHP_trend_count2, WR_GHP_trend_count2} = '0;
    {WR_LHP_index1, WR_GHP_index1, WR_LHP_index2, WR_GHP_index2} = '0;
    {WR_SP_stat_count1, WR_LHP_stat_count1, WR_GHP_stat_count1} = '0;
    {WR_SP_stat_count2, WR_LHP_stat_count2, WR_GHP_stat_count2} = '0;
  endtask

  // Inputs change on the falling edge; one call advances through one rising edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_if(input logic [2:0] a, input logic sp, input logic [1:0] l, input logic [1:0] g);
    addr = a; SP_prediction_result = sp; LHP_count = l; GHP_count = g;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_if(3'd3, 1'b0, 2'b10, 2'b01);
    n_cmp++; if (prediction_result !== 1'b0) begin n_err++; $display("FAIL reset_pred_ghp: got %b expected 0", prediction_result); end
    n_cmp++; if ({SP_stat_count, LHP_stat_count, GHP_stat_count} !== 15'd0) begin n_err++; $display("FAIL reset_stats: got %h expected 0", {SP_stat_count, LHP_stat_count, GHP_stat_count}); end
    n_cmp++; if ({addr_id, addr_ex, prediction_result_id} !== 7'd0) begin n_err++; $display("FAIL reset_copies: got %h expected 0", {addr_id, addr_ex, prediction_result_id}); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (addr_id !== 3'd3) begin n_err++; $display("FAIL reset_release_id: got %0d expected 3", addr_id); end
  endtask

  task automatic test_write_read();
    WR_addr1 = 3'd3; WR_LHP_index1 = 2'b10; WR_LHP_stat_count1 = 5'd9; WR_LHP_stat_en1 = 1'b1;
    set_if(3'd3, 1'b0, 2'b10, 2'b01);
    n_cmp++; if (LHP_stat_count !== 5'd0) begin n_err++; $display("FAIL no_bypass: got %0d expected 0", LHP_stat_count); end
    cyc();
    idle_writes();
    #1;
    n_cmp++; if (LHP_stat_count !== 5'd9) begin n_err++; $display("FAIL lhp_write: got %0d expected 9", LHP_stat_count); end
    n_cmp++; if (prediction_result !== 1'b1) begin n_err++; $display("FAIL lhp_selected: got %b expected 1", prediction_result); end
    cyc();
    n_cmp++; if (LHP_stat_count_id !== 5'd9 || prediction_result_id !== 1'b1) begin n_err++; $display("FAIL lhp_id_copy: got stat %0d pred %b expected 9/1", LHP_stat_count_id, prediction_result_id); end
  endtask

  task automatic test_dual_write_clear();
    WR_addr1 = 3'd5; WR_SP_index1 = 1'b1; WR_SP_stat_count1 = 5'd4; WR_SP_stat_en1 = 1'b1;
    WR_SP_trend_count1 = 3'd2; WR_SP_trend_en1 = 1'b1;
    WR_LHP_index1 = 2'b11; WR_LHP_stat_count1 = 5'd3; WR_LHP_stat_en1 = 1'b1;
    WR_addr2 = 3'd5; WR_SP_index2 = 1'b1; WR_SP_stat_count2 = 5'd7; WR_SP_stat_en2 = 1'b1;
    WR_GHP_index2 = 2'b00; WR_GHP_stat_count2 = 5'd2; WR_GHP_stat_en2 = 1'b1;
    cyc();
    idle_writes();
    set_if(3'd5, 1'b1, 2'b11, 2'b00);
    n_cmp++; if (SP_stat_count !== 5'd7) begin n_err++; $display("FAIL port2_wins: got %0d expected 7", SP_stat_count); end
    n_cmp++; if (LHP_stat_count !== 5'd3 || GHP_stat_count !== 5'd2) begin n_err++; $display("FAIL row5_other: got lhp %0d ghp %0d expected 3/2", LHP_stat_count, GHP_stat_count); end
    n_cmp++; if (prediction_result !== 1'b1) begin n_err++; $display("FAIL sp_selected: got %b expected 1", prediction_result); end
    clear_en1 = 1'b1; WR_addr1 = 3'd5;
    WR_addr2 = 3'd5; WR_GHP_index2 = 2'b01; WR_GHP_stat_count2 = 5'd6; WR_GHP_stat_en2 = 1'b1;
    cyc();
    idle_writes();
    set_if(3'd5, 1'b1, 2'b11, 2'b00);
    n_cmp++; if ({SP_stat_count, LHP_stat_count, GHP_stat_count} !== 15'd0) begin n_err++; $display("FAIL clear_row5: got %h expected 0", {SP_stat_count, LHP_stat_count, GHP_stat_count}); end
    n_cmp++; if (SP_trend_count !== 3'd2) begin n_err++; $display("FAIL clear_keeps_trend: got %0d expected 2", SP_trend_count); end
    set_if(3'd5, 1'b1, 2'b11, 2'b01);
    n_cmp++; if (GHP_stat_count !== 5'd0) begin n_err++; $display("FAIL clear_beats_write: got %0d expected 0", GHP_stat_count); end
    WR_addr1 = 3'd2; WR_SP_index1 = 1'b0; WR_SP_stat_count1 = 5'd8; WR_SP_stat_en1 = 1'b1;
    WR_addr2 = 3'd2; clear_en2 = 1'b1;
    cyc();
    idle_writes();
    set_if(3'd2, 1'b0, 2'b00, 2'b00);
    n_cmp++; if (SP_stat_count !== 5'd0) begin n_err++; $display("FAIL clear2_beats_port1: got %0d expected 0", SP_stat_count); end
  endtask

  task automatic test_tie_break();
    WR_addr1 = 3'd6; WR_SP_index1 = 1'b1; WR_SP_stat_count1 = 5'd4; WR_SP_stat_en1 = 1'b1;
    WR_LHP_index1 = 2'b01; WR_LHP_stat_count1 = 5'd4; WR_LHP_stat_en1 = 1'b1;
    WR_addr2 = 3'd6; WR_GHP_index2 = 2'b10; WR_GHP_stat_count2 = 5'd4; WR_GHP_stat_en2 = 1'b1;
    cyc();
    idle_writes();
    set_if(3'd6, 1'b1, 2'b01, 2'b00);
    n_cmp++; if (prediction_result !== 1'b0) begin n_err++; $display("FAIL tie_lhp_over_sp: got %b expected 0", prediction_result); end
    set_if(3'd6, 1'b0, 2'b01, 2'b10);
    n_cmp++; if (prediction_result !== 1'b1) begin n_err++; $display("FAIL tie_ghp_over_all: got %b expected 1", prediction_result); end
  endtask

  task automatic test_pipeline();
    set_if(3'd3, 1'b0, 2'b10, 2'b00);
    cyc();
    set_if(3'd2, 1'b0, 2'b00, 2'b00);
    cyc();
    n_cmp++; if (addr_id !== 3'd2 || addr_ex !== 3'd3) begin n_err++; $display("FAIL pipe_advance: got id %0d ex %0d expected 2/3", addr_id, addr_ex); end
    n_cmp++; if (LHP_stat_count_ex !== 5'd9 || prediction_result_ex !== 1'b1 || LHP_count_ex !== 2'b10) begin n_err++; $display("FAIL pipe_ex_fields: got %0d %b %b expected 9/1/10", LHP_stat_count_ex, prediction_result_ex, LHP_count_ex); end
    PL_stall = 1'b1;
    set_if(3'd4, 1'b1, 2'b01, 2'b01);
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++; if (addr_id !== 3'd2 || addr_ex !== 3'd3) begin n_err++; $display("FAIL stall_hold: got id %0d ex %0d expected 2/3", addr_id, addr_ex); end
    end
    PL_stall = 1'b0; PL_flush = 1'b1;
    set_if(3'd7, 1'b1, 2'b00, 2'b00);
    cyc();
    n_cmp++; if (addr_id !== 3'd0 || addr_ex !== 3'd2 || SP_prediction_result_id !== 1'b0) begin n_err++; $display("FAIL flush: got id %0d ex %0d expected 0/2", addr_id, addr_ex); end
    PL_stall = 1'b1;
    cyc();
    n_cmp++; if (addr_id !== 3'd0 || addr_ex !== 3'd2) begin n_err++; $display("FAIL flush_in_stall: got id %0d ex %0d expected 0/2", addr_id, addr_ex); end
    PL_stall = 1'b0; PL_flush = 1'b0;
    cyc();
    n_cmp++; if (addr_id !== 3'd7 || addr_ex !== 3'd0 || SP_prediction_result_id !== 1'b1) begin n_err++; $display("FAIL after_flush: got id %0d ex %0d expected 7/0", addr_id, addr_ex); end
  endtask

  task automatic test_trend();
    logic exp_pred;
`ifdef TREND_BIAS_EN
    exp_pred = 1'b1;
`else
    exp_pred = 1'b0;
`endif
    WR_addr1 = 3'd1; WR_SP_index1 = 1'b1; WR_SP_stat_count1 = 5'd6; WR_SP_stat_en1 = 1'b1;
    WR_SP_trend_count1 = 3'b001; WR_SP_trend_en1 = 1'b1;
    WR_addr2 = 3'd1; WR_GHP_index2 = 2'b00; WR_GHP_stat_count2 = 5'd7; WR_GHP_stat_en2 = 1'b1;
    WR_GHP_trend_count2 = 3'b110; WR_GHP_trend_en2 = 1'b1;
    cyc();
    idle_writes();
    set_if(3'd1, 1'b1, 2'b00, 2'b00);
    n_cmp++; if (SP_trend_count !== 3'b001 || GHP_trend_count !== 3'b110) begin n_err++; $display("FAIL trend_store: got %b %b expected 001/110", SP_trend_count, GHP_trend_count); end
    n_cmp++; if (prediction_result !== exp_pred) begin n_err++; $display("FAIL trend_select: got %b expected %b", prediction_result, exp_pred); end
    cyc();
  endtask

  task automatic test_reset_mid_write();
    set_if(3'd1, 1'b1, 2'b00, 2'b00);
    WR_addr1 = 3'd1; WR_SP_index1 = 1'b1; WR_SP_stat_count1 = 5'd20; WR_SP_stat_en1 = 1'b1;
    WR_SP_trend_count1 = 3'd3; WR_SP_trend_en1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({SP_stat_count, SP_trend_count, GHP_stat_count} !== 13'd0) begin n_err++; $display("FAIL async_reset_tables: got %h expected 0", {SP_stat_count, SP_trend_count, GHP_stat_count}); end
    n_cmp++; if ({addr_id, addr_ex, SP_stat_count_id} !== 11'd0) begin n_err++; $display("FAIL async_reset_copies: got %h expected 0", {addr_id, addr_ex, SP_stat_count_id}); end
    cyc();
    n_cmp++; if (SP_stat_count !== 5'd0 || addr_id !== 3'd0) begin n_err++; $display("FAIL reset_hold: got stat %0d id %0d expected 0/0", SP_stat_count, addr_id); end
    idle_writes();
    rst_n = 1'b1;
    set_if(3'd1, 1'b1, 2'b01, 2'b10);
    n_cmp++; if (SP_stat_count !== 5'd0 || prediction_result !== 1'b1) begin n_err++; $display("FAIL post_reset: got stat %0d pred %b expected 0/1", SP_stat_count, prediction_result); end
  endtask

  initial begin
    idle_writes();
    test_reset();
    test_write_read();
    test_dual_write_clear();
    test_tie_break();
    test_pipeline();
    test_trend();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prediction_reader.md
PREDICTION_READER -- requirements
Module: prediction_reader

Interface
REQ-001 Parameters: JUMP_STATUS_COUNTER_WIDTH, default 2, LHP/GHP jump-status counter width; STAT_COUNTER_WIDTH, default 5, unsigned stat counter width.
REQ-002 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 PL_stall input 1, holds the pipeline copies; PL_flush input 1, bubbles the ID copy.
REQ-004 addr input 3, IF-stage table entry.
REQ-005 SP_prediction_result input 1; LHP_count, GHP_count input JUMP_STATUS_COUNTER_WIDTH; IF-stage sub-predictor outputs.
REQ-006 Write port k (k=1,2): clear_enk input 1; WR_addrk input 3; WR_SP_indexk input 1; WR_LHP_indexk, WR_GHP_indexk input JUMP_STATUS_COUNTER_WIDTH.
REQ-007 Port k, per P in {SP,LHP,GHP}: WR_P_stat_enk input 1; WR_P_trend_enk input 1; WR_P_stat_countk input STAT_COUNTER_WIDTH; WR_P_trend_countk input 3 (signed).
REQ-008 prediction_result, prediction_result_id, prediction_result_ex output 1, selected prediction at IF/ID/EX.
REQ-009 addr_id, addr_ex output 3; SP_prediction_result_id/_ex output 1; LHP_count_id/_ex, GHP_count_id/_ex output JUMP_STATUS_COUNTER_WIDTH.
REQ-010 Per P: P_stat_count, P_stat_count_id, P_stat_count_ex output STAT_COUNTER_WIDTH; P_trend_count output 3 (IF only).

Function
REQ-011 SHALL hold tables: SP 8x2, LHP 8x2^JUMP_STATUS_COUNTER_WIDTH, GHP 8x2^JUMP_STATUS_COUNTER_WIDTH; each entry one stat counter and one 3-bit trend counter, in flops.
REQ-012 IF read is combinational from current table state, indexed {addr, SP_prediction_result}, {addr, LHP_count}, {addr, GHP_count}; writes become visible the cycle after the write edge; no write-to-read bypass.
REQ-013 Write port k, when WR_P_stat_enk, stores WR_P_stat_countk at {WR_addrk, WR_P_indexk}; trend likewise with WR_P_trend_enk.
REQ-014 clear_enk zeroes every stat counter (all indices, all three predictors) of row WR_addrk; trend counters untouched; clear overrides any stat write landing in that row in the same cycle.
REQ-015 Same entry written by both ports in one cycle: port 2 wins; clear_en2 overrides port-1 writes to row WR_addr2.
REQ-016 Selection score per P: zero-extended stat count; highest score selects; ties resolve GHP > LHP > SP.
REQ-017 prediction_result = SP_prediction_result, LHP_count MSB or GHP_count MSB according to the selected predictor, combinational, zero latency.
REQ-018 Pipeline: when !PL_stall, ID copies <= IF values and EX copies <= ID copies at each edge; when PL_stall, all ID/EX copies hold.
REQ-019 PL_flush with !PL_stall loads ID copies with 0 while EX still takes the old ID copies; PL_flush during PL_stall is ignored.
REQ-020 Table writes proceed regardless of PL_stall and PL_flush.

Reset
REQ-021 rst_n low asynchronously clears all table stat/trend counters and all ID/EX copies to 0; all are held at 0 while low.
REQ-022 After reset, prediction_result equals GHP_count MSB (all scores tied at 0); release is synchronous to the next clk edge.

Configuration
REQ-023 Macro TREND_BIAS_EN.
- Defined: score = stat + sign-extended trend, computed as a 7-bit signed value and compared signed.
- Undefined: score = stat only, and trend counters do not affect selection.
- Trend storage and outputs are identical in both builds.

Verification
REQ-024 Reset, then addr=3, LHP_count=2'b10, GHP_count=2'b01 -> prediction_result=1'b0 (GHP), all stat outputs 0.
REQ-025 Port 1 writes LHP stat 5'd9 at {3,2'b10}; next cycle addr=3, LHP_count=2'b10 -> LHP_stat_count=9, prediction_result=1.
REQ-026 Both ports write SP stat at {5,1} with 4 and 7 in the same cycle -> stored 7; clear_en1 on row 5 in the next cycle -> all row-5 stats read 0.
REQ-027 Stall for 2 cycles, then flush -> ID/EX copies held during stall; after flush addr_id=0 and addr_ex equals the pre-flush addr_id.
REQ-028 TREND_BIAS_EN defined, SP stat 6/trend 3'b001, GHP stat 7/trend 3'b110 -> SP selected; undefined -> GHP selected.
REQ-029 Assert rst_n mid-write -> tables and copies read 0 immediately; no write lands.
